// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding,
// default operand width and the bit-counter sizing helper.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_str.sv
// Single full-adder cell shared by the serial adder datapath.
module FA_str (
  output logic c_out,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  logic axb;

  assign axb   = a ^ b;
  assign sum   = axb ^ c_in;
  assign c_out = (a & b) | (c_in & axb);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FA cell, LSB first, one bit per clock,
// operands in and results out over valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | adding one bit position per cycle
// DONE  | result presented, waiting for done_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_c_out;

  FA_str u_fa (
    .c_out (fa_c_out),
    .sum   (fa_sum),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New sum bit enters at the MSB so the LSB ends up at bit 0.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c_out;
        if (cnt_q == CW'(WIDTH - 1)) begin
          ovf_d   = carry_q ^ fa_c_out;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign done_valid  = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum         = sum_q;
  assign c_out       = carry_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .c_out       (c_out),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands and let the next rising edge accept them.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a           = va;
    b           = vb;
    c_in        = vc;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  // Inputs are scrambled every RUN cycle; only the accepted values may count.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!done_valid && lat < 40) begin
      a    = W'($urandom);
      b    = W'($urandom);
      c_in = 1'($urandom);
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, W);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    chk({tag, " sum"}, sum, es);
    chk({tag, " c_out"}, c_out, ec);
    chk({tag, " ovf"}, ovf, eo);
  endtask

  task automatic release_res(input string tag, input int stall);
    repeat (stall) step();
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({tag, " idle after release"}, {start_ready, done_valid, busy}, 3'b100);
  endtask

  initial begin
    logic [W-1:0] ra, rb, held_sum;
    logic         rc, held_c, held_o;
    logic [W:0]   full;
    logic         seen_done;
    string        tag;

    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    c_in        = 1'b0;
    repeat (2) step();
    chk("reset flags", {start_ready, done_valid, busy}, 3'b100);
    chk("reset sum", sum, 8'h00);
    chk("reset c_out/ovf", {c_out, ovf}, 2'b00);
    rst_n = 1'b1;
    step();

    launch(8'h5A, 8'h3C, 1'b0);
    chk("5A+3C busy in run", {start_ready, done_valid, busy}, 3'b001);
    wait_done("5A+3C");
    check_res("5A+3C", 8'h96, 1'b0, 1'b1);
    release_res("5A+3C", 0);

    launch(8'hFF, 8'h01, 1'b0);
    wait_done("FF+01");
    check_res("FF+01", 8'h00, 1'b1, 1'b0);
    release_res("FF+01", 1);

    launch(8'h00, 8'h00, 1'b1);
    wait_done("00+00+1");
    check_res("00+00+1", 8'h01, 1'b0, 1'b0);
    release_res("00+00+1", 0);

    // Backpressure: result held, new operands refused until release.
    launch(8'h70, 8'h70, 1'b0);
    wait_done("bp");
    check_res("bp", 8'hE0, 1'b0, 1'b1);
    held_sum = sum;
    held_c   = c_out;
    held_o   = ovf;
    a           = 8'h40;
    b           = 8'h40;
    c_in        = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp stall%0d flags", i), {start_ready, done_valid, busy}, 3'b011);
      chk($sformatf("bp stall%0d result", i), {sum, c_out, ovf}, {held_sum, held_c, held_o});
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("bp idle after release", {start_ready, done_valid, busy}, 3'b100);
    step();
    start_valid = 1'b0;
    chk("bp new op accepted", {start_ready, busy}, 2'b01);
    wait_done("bp next");
    check_res("bp next", 8'h80, 1'b0, 1'b1);
    release_res("bp next", 0);

    // Reset during the third RUN cycle, carry and ovf both non-zero beforehand.
    launch(8'h0F, 8'h01, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrun rst flags", {start_ready, done_valid, busy}, 3'b100);
    chk("midrun rst result", {sum, c_out, ovf}, {8'h00, 1'b0, 1'b0});
    seen_done = 1'b0;
    repeat (12) begin
      step();
      seen_done = seen_done | done_valid;
    end
    chk("midrun no done pulse", seen_done, 1'b0);
    launch(8'h10, 8'h20, 1'b0);
    wait_done("10+20");
    check_res("10+20", 8'h30, 1'b0, 1'b0);
    release_res("10+20", 0);

    for (int n = 0; n < 2000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      tag  = $sformatf("rand%0d a=%02h b=%02h c_in=%0d", n, ra, rb, rc);
      launch(ra, rb, rc);
      wait_done(tag);
      check_res(tag, full[W-1:0], full[W],
                (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]));
      release_res(tag, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

- Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Sequences one shared 1-bit full adder (FA_str), one bit position per clock, LSB first, holding the carry in a flop.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits between the operand source and the result consumer, replacing a WIDTH-bit ripple adder with one FA cell plus control.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- start_valid  in  1  operands a, b, c_in valid
- start_ready  out  1  controller can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled only on accept
- b  in  WIDTH  operand B, sampled only on accept
- c_in  in  1  carry-in, sampled only on accept
- done_valid  out  1  result valid (high only in DONE)
- done_ready  in  1  consumer takes result
- sum  out  WIDTH  a + b + c_in, mod 2^WIDTH
- c_out  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN or DONE

## Operation
- State machine with three states:
  - IDLE: start_ready=1. Accept when start_valid&&start_ready at a rising edge: load a_sr<=a, b_sr<=b, carry<=c_in, sum_sr<=0, cnt<=0; go to RUN.
  - RUN, each cycle:
    - FA inputs: a_sr[0], b_sr[0], carry.
    - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}; a_sr, b_sr shift right by 1; carry <= fa_c_out.
    - When cnt==WIDTH-1: also latch ovf <= carry XOR fa_c_out (carry here is the carry into the MSB); go to DONE. Otherwise cnt<=cnt+1.
  - DONE: done_valid=1; sum=sum_sr, c_out=carry, ovf held stable. When done_ready is high at an edge, go to IDLE.
- cnt width: $clog2(WIDTH) bits, minimum 1; never wraps past WIDTH-1.
- Inputs a, b, c_in are ignored outside the accept edge; changing them mid-operation has no effect.
- start_valid during RUN/DONE is ignored (start_ready=0). No new accept occurs in the DONE→IDLE transition cycle, even if start_valid=1.
- done_ready outside DONE is ignored.
- sum, c_out, ovf are registered, never combinational from inputs. They change only on RUN cycles and hold their last values in IDLE until the next op.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, start_ready=1, done_valid=0, busy=0, sum=0, c_out=0, ovf=0, cnt=0, carry=0.
- Reset mid-RUN or mid-DONE aborts the operation; no done_valid pulse for it.
- Latency: accept at edge k → done_valid=1 after edge k+WIDTH (exactly WIDTH RUN cycles).
  - WIDTH=1: one RUN cycle.
- Back-to-back throughput: one result per WIDTH+2 cycles with done_ready tied high (accept, WIDTH RUN, DONE, IDLE).
- done_valid stays high with outputs stable for any number of cycles while done_ready=0.

## Structure
- Shared package serial_add_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE next edge.
  - default WIDTH constant.
- Single sub-module: one instance of the existing FA_str (ports c_out, sum, a, b, c_in). No other arithmetic in the block.
- Everything else (FSM, shift registers, counter, carry flop) lives in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- 0x5A + 0x3C, c_in=0 → sum=0x96, c_out=0, ovf=1; done_valid rises exactly 8 cycles after accept.
- 0xFF + 0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Then 0x00 + 0x00, c_in=1 → sum=0x01, c_out=0, ovf=0.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid. Required:
  - sum, c_out, ovf stable; start_ready=0.
  - start_valid=1 with new operands is not accepted.
  - After done_ready=1: IDLE next cycle, then the new op is accepted.
- Reset mid-RUN: assert rst_n=0 on the 3rd RUN cycle. Required:
  - next edge: IDLE, all outputs 0, no done_valid.
  - following op 0x10 + 0x20 → 0x30.
- Input perturbation: toggle a, b, c_in every cycle during RUN → result equals the accepted operands only.
- Random sweep: 2000 operand/c_in triples with random done_ready stalls, each checked against a behavioural a+b+c_in model for sum, c_out, ovf. Error message prints a, b, c_in on mismatch.
